// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the multi-cycle RISC controller
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_XORI  = 6'b010010;
    localparam logic [5:0] OP_BEQ   = 6'b010011;
    localparam logic [5:0] OP_BNE   = 6'b010100;
    localparam logic [5:0] OP_LW    = 6'b010101;
    localparam logic [5:0] OP_SW    = 6'b010110;
    localparam logic [5:0] OP_SLT   = 6'b010111;
    localparam logic [5:0] OP_SLTI  = 6'b011000;
    localparam logic [5:0] OP_J     = 6'b110000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_XOR   = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic rtype;
        logic alu_imm;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/opcode_class_decode.sv
// rtl/opcode_class_decode.sv - maps the IR opcode to one-hot class flags and ALU op
module opcode_class_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  cls,
    output logic [2:0] alu_op
);

    always_comb begin
        cls    = '0;
        alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE, OP_SLT: begin
                cls.rtype = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            OP_ADDI: begin
                cls.alu_imm = 1'b1;
                alu_op      = ALU_ADDI;
            end
            OP_ANDI: begin
                cls.alu_imm = 1'b1;
                alu_op      = ALU_AND;
            end
            OP_XORI: begin
                cls.alu_imm = 1'b1;
                alu_op      = ALU_XOR;
            end
            OP_SLTI: begin
                cls.alu_imm = 1'b1;
                alu_op      = ALU_SLT;
            end
            OP_BEQ: begin
                cls.branch = 1'b1;
                alu_op     = ALU_SUB;
            end
            OP_LW:   cls.load  = 1'b1;
            OP_SW:   cls.store = 1'b1;
            OP_J:    cls.jump  = 1'b1;
            // BNE is deliberately unsupported and lands here with everything else
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle sequencing FSM driving shared ALU and memory port
module multicycle_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] ir_opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       trap
);

    state_t     state_q, state_d;
    op_class_t  cls;
    logic [2:0] dec_alu_op;
    state_t     after_retire;

    opcode_class_decode u_decode (
        .opcode (ir_opcode),
        .cls    (cls),
        .alu_op (dec_alu_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign after_retire = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        retire        = 1'b0;
        trap          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut for a possible BEQ
                alu_src_b = SRCB_IMM_SH2;
                if (cls.jump) begin
                    pc_src   = PC_SRC_JUMP;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = after_retire;
                end else if (cls.illegal) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
                if (cls.rtype) begin
                    alu_src_b = SRCB_REG;
                    state_d   = S_WB;
                end else if (cls.alu_imm) begin
                    alu_src_b = SRCB_IMM;
                    state_d   = S_WB;
                end else if (cls.load || cls.store) begin
                    alu_src_b = SRCB_IMM;
                    state_d   = S_MEM;
                end else if (cls.branch) begin
                    alu_src_b     = SRCB_REG;
                    pc_write_cond = 1'b1;
                    pc_src        = PC_SRC_ALUOUT;
                    retire        = 1'b1;
                    state_d       = after_retire;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = cls.store;
                if (mem_ready) begin
                    if (cls.store) begin
                        retire  = 1'b1;
                        state_d = after_retire;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = cls.rtype;
                mem_to_reg = cls.load;
                retire     = 1'b1;
                state_d    = after_retire;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_SLT   = 6'b010111;
    localparam logic [5:0] T_ADDI  = 6'b010000;
    localparam logic [5:0] T_ANDI  = 6'b010001;
    localparam logic [5:0] T_XORI  = 6'b010010;
    localparam logic [5:0] T_SLTI  = 6'b011000;
    localparam logic [5:0] T_BEQ   = 6'b010011;
    localparam logic [5:0] T_LW    = 6'b010101;
    localparam logic [5:0] T_SW    = 6'b010110;
    localparam logic [5:0] T_J     = 6'b110000;
    localparam logic [5:0] T_BNE   = 6'b010100;

    localparam int K_R = 0, K_I = 1, K_L = 2, K_S = 3, K_B = 4, K_J = 5, K_X = 6;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       retire;
        logic       trap;
    } out_t;

    typedef struct {
        logic ready;
        logic run;
        out_t exp;
    } step_t;

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         mw;
        logic       run_end;
        int         latency;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [5:0] ir_opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write, reg_dst, mem_to_reg, retire, trap;
    out_t       act;

    int    checks = 0;
    int    failures = 0;
    step_t q[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .ir_opcode     (ir_opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .retire        (retire),
        .trap          (trap)
    );

    assign act = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, retire, trap};

    task automatic check_out(input string name, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%05h required=%05h", name, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, a, e);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            T_RTYPE, T_SLT:                 return K_R;
            T_ADDI, T_ANDI, T_XORI, T_SLTI: return K_I;
            T_LW:                           return K_L;
            T_SW:                           return K_S;
            T_BEQ:                          return K_B;
            T_J:                            return K_J;
            default:                        return K_X;
        endcase
    endfunction

    function automatic logic [2:0] exec_alu_op(input logic [5:0] op);
        case (op)
            T_RTYPE, T_SLT: return 3'b010;
            T_ADDI:         return 3'b011;
            T_ANDI:         return 3'b100;
            T_XORI:         return 3'b101;
            T_SLTI:         return 3'b110;
            T_BEQ:          return 3'b001;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic out_t fetch_out(input logic rdy);
        out_t o = '0;
        o.mem_req   = 1'b1;
        o.alu_src_b = 2'b01;
        o.ir_write  = rdy;
        o.pc_write  = rdy;
        return o;
    endfunction

    task automatic push(input logic rdy, input logic rn, input out_t e);
        step_t s;
        s.ready = rdy;
        s.run   = rn;
        s.exp   = e;
        q.push_back(s);
    endtask

    // Cycle-by-cycle expectation for one instruction, expanded from its class
    task automatic build(input logic [5:0] op, input int fw, input int mw, input logic run_end);
        int   k;
        out_t o;
        k = kind_of(op);
        for (int i = 0; i < fw; i++) push(1'b0, rbit(), fetch_out(1'b0));
        push(1'b1, rbit(), fetch_out(1'b1));
        o = '0;
        o.alu_src_b = 2'b11;
        if (k == K_J) begin
            o.pc_src   = 2'b10;
            o.pc_write = 1'b1;
            o.retire   = 1'b1;
            push(rbit(), run_end, o);
        end else begin
            push(rbit(), rbit(), o);
            if (k == K_X) begin
                o = '0;
                o.trap = 1'b1;
                for (int i = 0; i < 20; i++) push(rbit(), 1'b1, o);
                return;
            end
            o = '0;
            o.alu_src_a = 1'b1;
            o.alu_op    = exec_alu_op(op);
            o.alu_src_b = (k == K_R || k == K_B) ? 2'b00 : 2'b10;
            if (k == K_B) begin
                o.pc_write_cond = 1'b1;
                o.pc_src        = 2'b01;
                o.retire        = 1'b1;
                push(rbit(), run_end, o);
            end else begin
                push(rbit(), rbit(), o);
                if (k == K_L || k == K_S) begin
                    o = '0;
                    o.mem_req = 1'b1;
                    o.i_or_d  = 1'b1;
                    o.mem_we  = (k == K_S);
                    for (int i = 0; i < mw; i++) push(1'b0, rbit(), o);
                    o.retire = (k == K_S);
                    push(1'b1, (k == K_S) ? run_end : rbit(), o);
                end
                if (k != K_S) begin
                    o = '0;
                    o.reg_write  = 1'b1;
                    o.reg_dst    = (k == K_R);
                    o.mem_to_reg = (k == K_L);
                    o.retire     = 1'b1;
                    push(rbit(), run_end, o);
                end
            end
        end
        if (!run_end) begin
            push(rbit(), 1'b0, '0);
            push(rbit(), 1'b1, '0);
        end
    endtask

    // Entered and left just after a rising edge; compares on the falling edge
    task automatic apply(input string tag, output int lat);
        lat = -1;
        for (int i = 0; i < q.size(); i++) begin
            mem_ready = q[i].ready;
            run       = q[i].run;
            @(negedge clk);
            check_out($sformatf("%s step%0d", tag, i), act, q[i].exp);
            if (lat < 0 && act.retire) lat = i + 1;
            @(posedge clk);
            #1;
        end
        q.delete();
    endtask

    task automatic run_one(input string tag, input logic [5:0] op, input int fw, input int mw,
                           input logic run_end, output int lat);
        ir_opcode = op;
        build(op, fw, mw, run_end);
        apply(tag, lat);
    endtask

    task automatic reset_from_trap(input string tag);
        int lat;
        rst_n = 1'b0;
        #1;
        check_out({tag, " async_clear"}, act, '0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(1'b1, 1'b0, '0);
        push(1'b0, 1'b1, '0);
        apply({tag, " idle"}, lat);
    endtask

    vec_t       vecs[$];
    logic [5:0] legal[10];

    initial begin
        int   lat;
        out_t o;

        vecs.push_back('{T_RTYPE, 0, 0, 1'b1, 4});
        vecs.push_back('{T_RTYPE, 0, 0, 1'b1, 4});
        vecs.push_back('{T_SLT,   0, 0, 1'b1, 4});
        vecs.push_back('{T_ADDI,  0, 0, 1'b1, 4});
        vecs.push_back('{T_ANDI,  1, 0, 1'b1, 5});
        vecs.push_back('{T_XORI,  0, 0, 1'b1, 4});
        vecs.push_back('{T_SLTI,  0, 0, 1'b0, 4});
        vecs.push_back('{T_LW,    0, 0, 1'b1, 5});
        vecs.push_back('{T_LW,    2, 3, 1'b1, 10});
        vecs.push_back('{T_SW,    0, 0, 1'b1, 4});
        vecs.push_back('{T_SW,    1, 2, 1'b0, 7});
        vecs.push_back('{T_BEQ,   0, 0, 1'b1, 3});
        vecs.push_back('{T_J,     0, 0, 1'b1, 2});
        vecs.push_back('{T_J,     3, 0, 1'b1, 5});
        legal = '{T_RTYPE, T_SLT, T_ADDI, T_ANDI, T_XORI, T_SLTI, T_BEQ, T_LW, T_SW, T_J};

        rst_n     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b1;
        ir_opcode = T_RTYPE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_out("reset_state", act, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(1'b1, 1'b0, '0);
        push(1'b1, 1'b1, '0);
        apply("idle_start", lat);

        foreach (vecs[i]) begin
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].run_end, lat);
            check_int($sformatf("vec%0d latency", i), lat, vecs[i].latency);
        end

        for (int n = 0; n < 60; n++) begin
            run_one($sformatf("rnd%0d", n), legal[$urandom_range(0, 9)],
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0), lat);
        end

        // Reset pulse in the middle of a load's memory wait
        ir_opcode = T_LW;
        push(1'b1, 1'b1, fetch_out(1'b1));
        o = '0;
        o.alu_src_b = 2'b11;
        push(1'b1, 1'b0, o);
        o = '0;
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b10;
        push(1'b1, 1'b0, o);
        o = '0;
        o.mem_req = 1'b1;
        o.i_or_d  = 1'b1;
        push(1'b0, 1'b0, o);
        push(1'b0, 1'b1, o);
        apply("lw_pre_reset", lat);
        mem_ready = 1'b0;
        run       = 1'b1;
        #1;
        check_out("mem_wait_held", act, o);
        rst_n = 1'b0;
        #1;
        check_out("rst_mid_mem", act, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_one("lw_after_reset", T_LW, 0, 0, 1'b1, lat);
        check_int("lw_after_reset latency", lat, 5);

        run_one("bne_trap", T_BNE, 0, 0, 1'b1, lat);
        reset_from_trap("bne_trap");
        run_one("other_trap", 6'b111111, 1, 0, 1'b1, lat);
        reset_from_trap("other_trap");
        run_one("post_trap", T_ADDI, 0, 0, 1'b1, lat);
        check_int("post_trap latency", lat, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
